// File: rtl/mac_accum_signed.sv
// rtl/mac_accum_signed.sv - sign-extending product accumulator, LEN products per frame, valid/ready result
// Optional feature macro: MAC_SATURATE_EN (clamp on overflow instead of wrapping).
module mac_accum_signed #(
    parameter int N     = 4,
    parameter int M     = 5,
    parameter int ACC_W = 16,
    parameter int LEN   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N+M-1:0]   prod_i,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic             clear,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             ovf
);
    localparam int P   = N + M;
    localparam int EXT = ACC_W + 1 - P;
    localparam int CW  = $clog2(LEN + 1);

    localparam logic [0:0] S_ACCUM = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;

    generate
        if (ACC_W < P) begin : g_bad_acc_w
            $error("mac_accum_signed: ACC_W must be >= N+M");
        end
        if (LEN < 1) begin : g_bad_len
            $error("mac_accum_signed: LEN must be >= 1");
        end
    endgenerate

    logic [0:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [ACC_W-1:0] r_acc_out;
    logic             r_acc_valid;
    logic             r_ovf;

    logic [ACC_W:0]   w_sext;
    logic [ACC_W:0]   w_sum;
    logic             w_ovf;
    logic [ACC_W-1:0] w_acc_nxt;

    // One extra bit of headroom: signed overflow shows up as the top two bits disagreeing.
    assign w_sext = {{EXT{prod_i[P-1]}}, prod_i};
    assign w_sum  = {r_acc[ACC_W-1], r_acc} + w_sext;
    assign w_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];

`ifdef MAC_SATURATE_EN
    assign w_acc_nxt = !w_ovf       ? w_sum[ACC_W-1:0] :
                       w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                      {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_acc_out   <= '0;
            r_acc_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (clear) begin
            r_state     <= S_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_acc_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (r_state == S_ACCUM) begin
            if (prod_valid) begin
                r_acc <= w_acc_nxt;
                r_ovf <= r_ovf | w_ovf;
                if (r_cnt == CW'(LEN - 1)) begin
                    r_acc_out   <= w_acc_nxt;
                    r_acc_valid <= 1'b1;
                    r_cnt       <= CW'(LEN);
                    r_state     <= S_HOLD;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end else if (acc_ready) begin
            r_acc_valid <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_state     <= S_ACCUM;
        end
    end

    // Gated by rst_n so the handshake drops the instant reset asserts.
    assign prod_ready = rst_n & (r_state == S_ACCUM);
    assign acc_out    = r_acc_out;
    assign acc_valid  = r_acc_valid;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_mac_accum_signed.sv
// tb/tb_mac_accum_signed.sv - directed self-checking bench for mac_accum_signed (N=4, M=5, ACC_W=10, LEN=4)
module tb_mac_accum_signed;
    logic       clk;
    logic       rst_n;
    logic [8:0] prod_i;
    logic       prod_valid;
    logic       prod_ready;
    logic       clear;
    logic [9:0] acc_out;
    logic       acc_valid;
    logic       acc_ready;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    mac_accum_signed #(.N(4), .M(5), .ACC_W(10), .LEN(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_i     (prod_i),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .clear      (clear),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one product and hold it until the handshake edge has passed.
    task automatic push(input int v);
        int n;
        n = 0;
        prod_i     = 9'(v);
        prod_valid = 1'b1;
        while (!prod_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("push_timeout", int'(n < 50), 1);
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
    endtask

    logic [6:0] pat;
    int vals[4];
    int k;
    int exp2;

    initial begin
        rst_n      = 1'b0;
        prod_i     = '0;
        prod_valid = 1'b0;
        clear      = 1'b0;
        acc_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_acc_out",    int'($signed(acc_out)), 0);
        chk("rst_acc_valid",  int'(acc_valid), 0);
        chk("rst_ovf",        int'(ovf), 0);
        chk("rst_prod_ready", int'(prod_ready), 1);

        // 1: 3,-5,7,1 back-to-back
        push(3); push(-5); push(7);
        @(negedge clk);
        chk("t1_valid_early", int'(acc_valid), 0);
        push(1);
        @(negedge clk);
        chk("t1_valid", int'(acc_valid), 1);
        chk("t1_acc",   int'($signed(acc_out)), 6);
        chk("t1_ovf",   int'(ovf), 0);
        chk("t1_ready_hold", int'(prod_ready), 0);
        @(negedge clk);
        chk("t1_ready_back", int'(prod_ready), 1);
        chk("t1_valid_drop", int'(acc_valid), 0);

        // 2: four products of +128 overflow ACC_W=10
`ifdef MAC_SATURATE_EN
        exp2 = 511;
`else
        exp2 = -512;
`endif
        repeat (4) push(128);
        @(negedge clk);
        chk("t2_valid", int'(acc_valid), 1);
        chk("t2_acc",   int'($signed(acc_out)), exp2);
        chk("t2_ovf",   int'(ovf), 1);
        @(negedge clk);
        chk("t2_ovf_clr", int'(ovf), 0);

        // 3: downstream stalls while a product waits
        acc_ready = 1'b0;
        push(1); push(2); push(3); push(4);
        prod_i     = 9'd5;
        prod_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_ready_stall", int'(prod_ready), 0);
            chk("t3_valid_stall", int'(acc_valid), 1);
            chk("t3_acc_stall",   int'($signed(acc_out)), 10);
        end
        acc_ready = 1'b1;
        @(posedge clk);
        #1;
        push(5); push(1); push(1); push(1);
        @(negedge clk);
        chk("t3_acc_next", int'($signed(acc_out)), 8);

        // 4: clear mid-frame drops partial sum and the concurrent product
        push(50); push(50);
        clear      = 1'b1;
        prod_i     = 9'd77;
        prod_valid = 1'b1;
        @(posedge clk);
        #1;
        clear      = 1'b0;
        prod_valid = 1'b0;
        @(negedge clk);
        chk("t4_clr_valid",   int'(acc_valid), 0);
        chk("t4_clr_acc_out", int'($signed(acc_out)), 8);
        chk("t4_clr_ovf",     int'(ovf), 0);
        repeat (4) push(1);
        @(negedge clk);
        chk("t4_acc", int'($signed(acc_out)), 4);
        chk("t4_ovf", int'(ovf), 0);

        // 5: asynchronous reset mid-frame
        @(posedge clk);
        #1;
        push(-7); push(-7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_acc_out",    int'($signed(acc_out)), 0);
        chk("t5_rst_valid",      int'(acc_valid), 0);
        chk("t5_rst_ovf",        int'(ovf), 0);
        chk("t5_rst_prod_ready", int'(prod_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t5_ready_release", int'(prod_ready), 1);
        repeat (4) push(-2);
        @(negedge clk);
        chk("t5_acc", int'($signed(acc_out)), -8);

        // 6: prod_valid gaps; only handshakes count
        @(posedge clk);
        #1;
        pat     = 7'b1101001;
        vals[0] = 10; vals[1] = 20; vals[2] = 30; vals[3] = 40;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            prod_valid = pat[i];
            prod_i     = 9'(vals[k]);
            @(posedge clk);
            if (pat[i]) k++;
            @(negedge clk);
            chk("t6_valid_step", int'(acc_valid), int'(i == 6));
        end
        prod_valid = 1'b0;
        chk("t6_acc", int'($signed(acc_out)), 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
